// File: rtl/dps_timer.sv
// dps_timer: register-mapped interval timer with a 2-entry read response FIFO.
// Define DPS_TIMER_64BIT_EN for a 64-bit counter with a COUNT_HI snapshot at 0x14.
module dps_timer #(
  parameter int unsigned P_PRESCALE = 1,
  parameter logic [5:0]  P_IRQ_NUM  = 6'h1,
  parameter logic [31:0] P_DPS_SIZE = 32'h20
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iDPS_REQ,
  output logic        oDPS_BUSY,
  input  logic        iDPS_RW,
  input  logic [31:0] iDPS_ADDR,
  input  logic [31:0] iDPS_DATA,
  output logic        oDPS_VALID,
  input  logic        iDPS_BUSY,
  output logic [31:0] oDPS_DATA,
  output logic        oDPS_IRQ_REQ,
  output logic [5:0]  oDPS_IRQ_NUM,
  input  logic        iDPS_IRQ_ACK
);

`ifdef DPS_TIMER_64BIT_EN
  localparam int CW = 64;
`else
  localparam int CW = 32;
`endif

  localparam logic [15:0] PRE_MAX = 16'(P_PRESCALE - 1);

  typedef enum logic {
    IRQ_IDLE,
    IRQ_PEND
  } irq_state_t;

  logic        accept;
  logic        rd_req;
  logic        wr_req;
  logic [2:0]  sel;
  logic        wr_ctrl;
  logic        wr_cmp;
  logic        wr_stat;
  logic        clr;

  logic        en_q;
  logic        irq_en_q;
  logic        auto_q;
  logic        match_q;
  logic [31:0] cmp_q;
  logic [15:0] pre_q;
  logic [CW-1:0] cnt_q;

  logic        tick;
  logic        hi_zero;
  logic        match;
  logic        irq_set;
  logic [31:0] rd_hi;
  logic [31:0] rd_data;

  irq_state_t  irq_q;
  irq_state_t  irq_nxt;

  logic [31:0] mem_q [2];
  logic        wptr_q;
  logic        rptr_q;
  logic [1:0]  fifo_cnt_q;
  logic        push;
  logic        pop;

  logic        unused_addr;

  assign unused_addr = ^{iDPS_ADDR[31:5], iDPS_ADDR[1:0]};

  assign accept  = iDPS_REQ && !oDPS_BUSY;
  assign rd_req  = accept && !iDPS_RW;
  assign wr_req  = accept && iDPS_RW;
  assign sel     = iDPS_ADDR[4:2];
  assign wr_ctrl = wr_req && (sel == 3'd0);
  assign wr_cmp  = wr_req && (sel == 3'd3);
  assign wr_stat = wr_req && (sel == 3'd4);
  assign clr     = wr_ctrl && iDPS_DATA[2];

  // prescaler phase 0 is the tick cycle, so enabling ticks on the first cycle
  assign tick    = en_q && (pre_q == 16'd0);
  assign match   = tick && !clr && hi_zero && (cnt_q[31:0] == cmp_q);
  assign irq_set = match && irq_en_q;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      auto_q   <= 1'b0;
      cmp_q    <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q     <= iDPS_DATA[0];
        irq_en_q <= iDPS_DATA[1];
        auto_q   <= iDPS_DATA[3];
      end
      if (wr_cmp) cmp_q <= iDPS_DATA;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      pre_q <= '0;
    end else if (!en_q || clr) begin
      pre_q <= '0;
    end else if (pre_q == PRE_MAX) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 16'd1;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      if (match && auto_q) cnt_q <= '0;
      else                 cnt_q <= cnt_q + CW'(1);
    end
  end

  // a match wins over a same-cycle software clear
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      match_q <= 1'b0;
    end else if (match) begin
      match_q <= 1'b1;
    end else if (wr_stat && iDPS_DATA[0]) begin
      match_q <= 1'b0;
    end
  end

`ifdef DPS_TIMER_64BIT_EN
  logic [31:0] cnt_hi_q;

  assign hi_zero = (cnt_q[63:32] == 32'd0);
  assign rd_hi   = cnt_hi_q;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      cnt_hi_q <= '0;
    end else if (rd_req && (sel == 3'd2)) begin
      cnt_hi_q <= cnt_q[63:32];
    end
  end
`else
  assign hi_zero = 1'b1;
  assign rd_hi   = 32'd0;
`endif

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) irq_q <= IRQ_IDLE;
    else        irq_q <= irq_nxt;
  end

  always_comb begin
    irq_nxt = irq_q;
    unique case (irq_q)
      IRQ_IDLE: if (irq_set) irq_nxt = IRQ_PEND;
      IRQ_PEND: if (iDPS_IRQ_ACK && !irq_set) irq_nxt = IRQ_IDLE;
    endcase
  end

  assign oDPS_IRQ_REQ = (irq_q == IRQ_PEND);
  assign oDPS_IRQ_NUM = P_IRQ_NUM;

  always_comb begin
    rd_data = 32'd0;
    case (sel)
      3'd0:    rd_data = {28'd0, auto_q, 1'b0, irq_en_q, en_q};
      3'd1:    rd_data = P_DPS_SIZE;
      3'd2:    rd_data = cnt_q[31:0];
      3'd3:    rd_data = cmp_q;
      3'd4:    rd_data = {31'd0, match_q};
      3'd5:    rd_data = rd_hi;
      default: rd_data = 32'd0;
    endcase
  end

  // reads land in the FIFO at the accept edge, so none are ever in flight
  assign push       = rd_req;
  assign pop        = oDPS_VALID && !iDPS_BUSY;
  assign oDPS_VALID = (fifo_cnt_q != 2'd0);
  assign oDPS_DATA  = mem_q[rptr_q];
  assign oDPS_BUSY  = (fifo_cnt_q >= 2'd2);

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= rd_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dps_timer.sv
// tb_dps_timer: directed bench; u4 runs P_PRESCALE=4, u1 runs P_PRESCALE=1.
// Both instances share one request bus and see identical transactions.
module tb_dps_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dbusy;
  logic        ack;

  logic        busy4, valid4, irq4;
  logic [31:0] data4;
  logic [5:0]  num4;
  logic        busy1, valid1, irq1;
  logic [31:0] data1;
  logic [5:0]  num1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dps_timer #(.P_PRESCALE(4)) u4 (
    .iCLOCK(clk), .iRESET(rst), .iDPS_REQ(req), .oDPS_BUSY(busy4),
    .iDPS_RW(rw), .iDPS_ADDR(addr), .iDPS_DATA(wdata),
    .oDPS_VALID(valid4), .iDPS_BUSY(dbusy), .oDPS_DATA(data4),
    .oDPS_IRQ_REQ(irq4), .oDPS_IRQ_NUM(num4), .iDPS_IRQ_ACK(ack)
  );

  dps_timer #(.P_PRESCALE(1)) u1 (
    .iCLOCK(clk), .iRESET(rst), .iDPS_REQ(req), .oDPS_BUSY(busy1),
    .iDPS_RW(rw), .iDPS_ADDR(addr), .iDPS_DATA(wdata),
    .oDPS_VALID(valid1), .iDPS_BUSY(dbusy), .oDPS_DATA(data1),
    .oDPS_IRQ_REQ(irq1), .oDPS_IRQ_NUM(num1), .iDPS_IRQ_ACK(ack)
  );

  // called just after a rising edge; accepts at the end of that cycle
  task automatic issue(input logic rw_v, input logic [31:0] a,
                       input logic [31:0] d);
    int n = 0;
    rw = rw_v; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    while (busy4 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL issue_timeout: busy=%0b after %0d cycles, want 0", busy4, n);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d4,
                         output logic [31:0] d1);
    int n = 0;
    issue(1'b0, a, 32'd0);
    @(negedge clk);
    while (!valid1 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL read_timeout: valid=%0b, want 1", valid1);
    end
    d4 = data4; d1 = data1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    dbusy = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy4); end
    checks++;
    if (valid4 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", valid4); end
    checks++;
    if (data4 !== 32'd0) begin errors++; $display("FAIL rst_data: got %08h want 0", data4); end
    checks++;
    if (irq4 !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0b want 0", irq4); end
    checks++;
    if (num4 !== 6'h1) begin errors++; $display("FAIL rst_irqnum: got %0h want 1", num4); end
    @(posedge clk); #1;
  endtask

  task automatic test_info_read();
    issue(1'b0, 32'h4, 32'd0);
    @(negedge clk);
    checks++;
    if (valid4 !== 1'b1) begin errors++; $display("FAIL info_valid: got %0b want 1", valid4); end
    checks++;
    if (data4 !== 32'h20) begin errors++; $display("FAIL info_data: got %08h want 00000020", data4); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (valid4 !== 1'b0) begin errors++; $display("FAIL info_pulse: got %0b want 0", valid4); end
    @(posedge clk); #1;
  endtask

  task automatic test_irq();
    logic [31:0] d4, d1;
    issue(1'b1, 32'hC, 32'd3);
    issue(1'b1, 32'h0, 32'h3);
    // ticks fall 1,5,9,13 cycles after the write; the 4th sees COUNT==3
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 13) begin
        checks++;
        if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_early: got %0b want 0", irq4); end
      end
      if (j == 14) begin
        checks++;
        if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_set: got %0b want 1", irq4); end
      end
      @(posedge clk); #1;
    end
    do_read(32'h10, d4, d1);
    checks++;
    if (d4 !== 32'd1) begin errors++; $display("FAIL match_set: got %08h want 1", d4); end
    issue(1'b1, 32'h10, 32'd1);
    do_read(32'h10, d4, d1);
    checks++;
    if (d4 !== 32'd0) begin errors++; $display("FAIL match_clr: got %08h want 0", d4); end
    @(negedge clk);
    checks++;
    if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_hold: got %0b want 1", irq4); end
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_ack: got %0b want 0", irq4); end
    @(posedge clk); #1;
    issue(1'b1, 32'h0, 32'h4);
    do_read(32'h8, d4, d1);
    checks++;
    if (d4 !== 32'd0) begin errors++; $display("FAIL count_clr: got %08h want 0", d4); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'h0, 32'h5);
    dbusy = 1'b1; req = 1'b1; rw = 1'b0; addr = 32'h8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d: got %0b want 1", i, busy1); end
      checks++;
      if (valid1 !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %0b want 1", i, valid1); end
      checks++;
      if (data1 !== 32'd0) begin errors++; $display("FAIL b2b_hold%0d: got %08h want 0", i, data1); end
      @(posedge clk); #1;
    end
    dbusy = 1'b0;
    @(negedge clk);
    checks++;
    if (data1 !== 32'd0) begin errors++; $display("FAIL b2b_r0: got %08h want 0", data1); end
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_busy_pop: got %0b want 1", busy1); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (data1 !== 32'd1) begin errors++; $display("FAIL b2b_r1: got %08h want 1", data1); end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_free: got %0b want 0", busy1); end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (valid1 !== 1'b1 || data1 !== 32'd7) begin
      errors++; $display("FAIL b2b_r2: got %0b/%08h want 1/00000007", valid1, data1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (valid1 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", valid1); end
    @(posedge clk); #1;
    issue(1'b1, 32'h0, 32'h4);
  endtask

  task automatic test_auto_reload();
    logic [31:0] ec [8];
    logic        ei [8];
    ec = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
    ei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    issue(1'b1, 32'hC, 32'd2);
    issue(1'b1, 32'h0, 32'hF);
    req = 1'b1; rw = 1'b0; addr = 32'h8; ack = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        checks++;
        if (valid1 !== 1'b1 || data1 !== ec[j]) begin
          errors++; $display("FAIL reload_cnt%0d: got %0b/%08h want 1/%08h", j, valid1, data1, ec[j]);
        end
      end
      checks++;
      if (irq1 !== ei[j]) begin errors++; $display("FAIL reload_irq%0d: got %0b want %0b", j, irq1, ei[j]); end
      @(posedge clk); #1;
      if (j == 6) req = 1'b0;
    end
    ack = 1'b0;
    issue(1'b1, 32'h0, 32'h4);
  endtask

  task automatic test_status_race();
    logic [31:0] d4, d1;
    issue(1'b1, 32'h10, 32'd1);
    issue(1'b1, 32'h0, 32'h5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b1; rw = 1'b1; addr = 32'h10; wdata = 32'd1;
    @(posedge clk); #1;
    req = 1'b0;
    do_read(32'h10, d4, d1);
    checks++;
    if (d1 !== 32'd1) begin errors++; $display("FAIL match_race: got %08h want 1", d1); end
    issue(1'b1, 32'h10, 32'd1);
    do_read(32'h10, d4, d1);
    checks++;
    if (d1 !== 32'd0) begin errors++; $display("FAIL match_w1c: got %08h want 0", d1); end
    issue(1'b1, 32'h0, 32'h4);
  endtask

  task automatic test_ack_race();
    issue(1'b1, 32'h0, 32'hF);
    for (int j = 1; j <= 5; j++) begin
      if (j == 5) begin
        @(negedge clk);
        checks++;
        if (irq1 !== 1'b1) begin errors++; $display("FAIL race_pend: got %0b want 1", irq1); end
      end
      @(posedge clk); #1;
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL race_ack_match: got %0b want 1", irq1); end
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL race_ack: got %0b want 0", irq1); end
    @(posedge clk); #1;
    issue(1'b1, 32'h0, 32'h4);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d4, d1;
    dbusy = 1'b1;
    issue(1'b0, 32'h4, 32'd0);
    issue(1'b0, 32'hC, 32'd0);
    @(negedge clk);
    checks++;
    if (valid1 !== 1'b1 || busy1 !== 1'b1) begin
      errors++; $display("FAIL mid_queued: got %0b/%0b want 1/1", valid1, busy1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid1 !== 1'b0 || valid4 !== 1'b0) begin
      errors++; $display("FAIL mid_valid: got %0b/%0b want 0/0", valid1, valid4);
    end
    checks++;
    if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL mid_busy: got %0b/%0b want 0/0", busy1, busy4);
    end
    @(posedge clk); #1;
    rst = 1'b0; dbusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (valid1 !== 1'b0) begin errors++; $display("FAIL mid_ghost%0d: got %0b want 0", i, valid1); end
      @(posedge clk); #1;
    end
    checks++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL mid_irq: got %0b want 0", irq1); end
    do_read(32'h0, d4, d1);
    checks++;
    if (d1 !== 32'd0) begin errors++; $display("FAIL mid_ctrl: got %08h want 0", d1); end
  endtask

  initial begin
    test_reset();
    test_info_read();
    test_irq();
    test_back_to_back();
    test_auto_reload();
    test_status_race();
    test_ack_race();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1);
  end

endmodule
